inst_queue: RTL and testbench

INST_QUEUE -- requirements
Module: inst_queue

---
 rtl/inst_queue_pkg.sv | 13 +
 rtl/inst_queue_mem.sv | 27 ++
 rtl/inst_queue.sv | 98 +++++++++
 tb/tb_inst_queue.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// Shared types for the fetch-to-decode instruction queue.
// Holds the default pc/instruction widths and the stored entry layout.
package inst_queue_pkg;

   localparam int IQ_PC_W   = 16;
   localparam int IQ_INST_W = 32;

   typedef struct packed {
      logic [IQ_PC_W-1:0]   pc;
      logic [IQ_INST_W-1:0] inst;
   } iq_entry_t;

endpackage

// File: rtl/inst_queue_mem.sv
// Instruction queue storage: DEPTH entries, one write port, one asynchronous read port.
// Contents are intentionally not reset; occupancy is tracked by the queue control logic.
module inst_queue_mem
   import inst_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  iq_entry_t         wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output iq_entry_t         rd_data
);

   iq_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: a DEPTH-entry FIFO of pc/instruction pairs with flush.
// Optional macro INST_QUEUE_BYPASS_EN lets an incoming pair reach decode combinationally when empty.
module inst_queue
   import inst_queue_pkg::*;
#(
   parameter int DEPTH  = 4,
   parameter int PC_W   = IQ_PC_W,
   parameter int INST_W = IQ_INST_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [PC_W-1:0]          in_pc,
   input  logic [INST_W-1:0]        in_inst,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [PC_W-1:0]          out_pc,
   output logic [INST_W-1:0]        out_inst,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] count_q;
   logic             full;
   logic             empty;
   logic             push;
   logic             pop;
   iq_entry_t        wr_entry;
   iq_entry_t        rd_entry;

   assign full     = (count_q == FULL_COUNT);
   assign empty    = (count_q == '0);
   assign in_ready = !full;
   assign count    = count_q;
   assign wr_entry = '{pc: IQ_PC_W'(in_pc), inst: IQ_INST_W'(in_inst)};

`ifdef INST_QUEUE_BYPASS_EN
   // An empty queue forwards the incoming pair; it is only stored if decode does not take it.
   logic bypass;

   assign bypass    = rst && empty && in_valid && !flush;
   assign out_valid = (!empty && !flush) || bypass;
   assign out_pc    = bypass ? in_pc   : PC_W'(rd_entry.pc);
   assign out_inst  = bypass ? in_inst : INST_W'(rd_entry.inst);
   assign push      = in_valid && in_ready && !flush && !(bypass && out_ready);
   assign pop       = out_valid && out_ready && !empty;
`else
   assign out_valid = !empty && !flush;
   assign out_pc    = PC_W'(rd_entry.pc);
   assign out_inst  = INST_W'(rd_entry.inst);
   assign push      = in_valid && in_ready && !flush;
   assign pop       = out_valid && out_ready;
`endif

   inst_queue_mem #(
      .DEPTH (DEPTH)
   ) u_mem (
      .clk     (clk),
      .wr_en   (push),
      .wr_addr (wr_ptr),
      .wr_data (wr_entry),
      .rd_addr (rd_ptr),
      .rd_data (rd_entry)
   );

   // Pointers wrap naturally because DEPTH is a power of two; flush wins over push and pop.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else if (flush) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_queue.sv
// Directed self-checking bench for inst_queue (default DEPTH=4, PC_W=16, INST_W=32).
// Also covers the INST_QUEUE_BYPASS_EN build when that macro is defined for both files.
module tb_inst_queue;

   localparam int DEPTH  = 4;
   localparam int PC_W   = 16;
   localparam int INST_W = 32;
   localparam int CNT_W  = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [PC_W-1:0]   in_pc;
   logic [INST_W-1:0] in_inst;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [PC_W-1:0]   out_pc;
   logic [INST_W-1:0] out_inst;
   logic [CNT_W-1:0]  count;

   int assertCount = 0;
   int failCount   = 0;

   always #5 clk = ~clk;

   inst_queue #(
      .DEPTH  (DEPTH),
      .PC_W   (PC_W),
      .INST_W (INST_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_pc     (in_pc),
      .in_inst   (in_inst),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_pc    (out_pc),
      .out_inst  (out_inst),
      .count     (count)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
      end
   endtask

   // Instruction words are derived from the pc so out_inst can be checked alongside out_pc.
   task automatic applyStimulus(input logic v, input logic [PC_W-1:0] pc, input logic fl, input logic ordy);
      in_valid  = v;
      in_pc     = pc;
      in_inst   = {16'hC0DE, pc};
      flush     = fl;
      out_ready = ordy;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0;
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #2;
      checkOutput("reset_count", 64'(count), 64'd0);
      checkOutput("reset_out_valid", 64'(out_valid), 64'd0);
      #10;
      rst = 1'b1;
      #1;
      checkOutput("reset_in_ready", 64'(in_ready), 64'd1);

      $display("[TB] three pushes, decode stalled");
      applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("push3_count", 64'(count), 64'd3);
      checkOutput("push3_out_valid", 64'(out_valid), 64'd1);
      checkOutput("push3_out_pc", 64'(out_pc), 64'h0000);
      checkOutput("push3_out_inst", 64'(out_inst), 64'hC0DE0000);
      tick();
      checkOutput("push3_hold_pc", 64'(out_pc), 64'h0000);

      $display("[TB] fill, reject extra push, drain");
      applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("full_count", 64'(count), 64'd4);
      checkOutput("full_in_ready", 64'(in_ready), 64'd0);
      applyStimulus(1'b1, 16'h0008, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      #1;
      checkOutput("full_no_5th", 64'(count), 64'd4);
      for (int i = 0; i < 4; i++) begin
         logic [PC_W-1:0] expPc;
         expPc = 16'(2 * i);
         #1;
         checkOutput("drain_pc", 64'(out_pc), 64'(expPc));
         tick();
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("drain_count", 64'(count), 64'd0);
      checkOutput("drain_out_valid", 64'(out_valid), 64'd0);

      $display("[TB] simultaneous push/pop across pointer wrap");
      applyStimulus(1'b1, 16'h0020, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h0022, 1'b0, 1'b0);
      tick();
      for (int k = 0; k < 10; k++) begin
         logic [PC_W-1:0] expHead;
         expHead = 16'(32'h20 + 2 * k);
         applyStimulus(1'b1, 16'(32'h24 + 2 * k), 1'b0, 1'b1);
         #1;
         checkOutput("pp_head_pc", 64'(out_pc), 64'(expHead));
         checkOutput("pp_count", 64'(count), 64'd2);
         tick();
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("pp_final_count", 64'(count), 64'd2);
      checkOutput("pp_final_pc", 64'(out_pc), 64'h0034);
      checkOutput("pp_final_inst", 64'(out_inst), 64'hC0DE0034);

      $display("[TB] flush with a concurrent push");
      applyStimulus(1'b1, 16'h0038, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b1, 16'h1010, 1'b1, 1'b1);
      #1;
      checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
      checkOutput("flush_pre_count", 64'(count), 64'd3);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("flush_count", 64'(count), 64'd0);
      checkOutput("flush_after_valid", 64'(out_valid), 64'd0);
      for (int j = 0; j < 3; j++) begin
         applyStimulus(1'b1, 16'h1010, 1'b1, 1'b1);
         #1;
         checkOutput("flush_held_valid", 64'(out_valid), 64'd0);
         tick();
         checkOutput("flush_held_count", 64'(count), 64'd0);
      end
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      #1;
      checkOutput("flush_no_1010", 64'(out_valid), 64'd0);

      $display("[TB] write-to-read latency after flush");
      applyStimulus(1'b1, 16'h0040, 1'b0, 1'b0);
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      checkOutput("lat_bypass_valid", 64'(out_valid), 64'd1);
      checkOutput("lat_bypass_pc", 64'(out_pc), 64'h0040);
`else
      checkOutput("lat_same_cycle_valid", 64'(out_valid), 64'd0);
`endif
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("lat_out_valid", 64'(out_valid), 64'd1);
      checkOutput("lat_out_pc", 64'(out_pc), 64'h0040);
      checkOutput("lat_count", 64'(count), 64'd1);

      $display("[TB] asynchronous reset mid-operation");
      applyStimulus(1'b1, 16'h0042, 1'b0, 1'b0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("arst_pre_count", 64'(count), 64'd2);
      #1;
      rst = 1'b0;
      #1;
      checkOutput("arst_count", 64'(count), 64'd0);
      checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
      checkOutput("arst_release_count", 64'(count), 64'd0);

      $display("[TB] empty queue, pair presented with decode ready");
      applyStimulus(1'b1, 16'h1011, 1'b0, 1'b1);
      #1;
`ifdef INST_QUEUE_BYPASS_EN
      checkOutput("byp_out_valid", 64'(out_valid), 64'd1);
      checkOutput("byp_out_pc", 64'(out_pc), 64'h1011);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("byp_count", 64'(count), 64'd0);
      checkOutput("byp_after_valid", 64'(out_valid), 64'd0);
`else
      checkOutput("nobyp_out_valid", 64'(out_valid), 64'd0);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
      #1;
      checkOutput("nobyp_count", 64'(count), 64'd1);
      checkOutput("nobyp_out_pc", 64'(out_pc), 64'h1011);
      tick();
      applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
      #1;
      checkOutput("nobyp_drain_count", 64'(count), 64'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
